// File: rtl/dram_strobe_seq.sv
`default_nettype none
// ============================================================================
//  Module      : dram_strobe_seq
//  Description : DRAM RAS/CAS/address-mux sequencer for a two-half phi cycle
//                (VIC half at ticks 0-15, CPU half at ticks 16-31) running on
//                the 4x dot clock, with an 8-bit refresh row counter.
//                Optional build macro RAS_ONLY_REFRESH_EN keeps cas_n high
//                during refresh halves (RAS-only refresh).
//  Revision    : 1.0 - initial release
// ============================================================================
module dram_strobe_seq (
    input  logic       clk_dot4x,
    input  logic       rst,
    input  logic       phi_sync,
    input  logic       vic_req,
    input  logic       refresh,
    input  logic       cpu_req,
    input  logic       refc_reload,
    output logic       mux,
    output logic       ras_n,
    output logic       cas_n,
    output logic [7:0] refc,
    output logic [4:0] tick,
    output logic       busy
);

`ifdef RAS_ONLY_REFRESH_EN
    localparam logic c_RAS_ONLY = 1'b1;
`else
    localparam logic c_RAS_ONLY = 1'b0;
`endif

    localparam logic [4:0] c_TICK_LAST = 5'd31;
    localparam logic [4:0] c_TICK_VIC  = 5'd0;
    localparam logic [4:0] c_TICK_CPU  = 5'd16;

    // PRE: precharge/idle, ROW: row address with RAS, RAS: column address
    // set-up, COL: first CAS tick, CAS: CAS held until precharge.
    typedef enum logic [2:0] {
        S_PRE = 3'd0,
        S_ROW = 3'd1,
        S_RAS = 3'd2,
        S_COL = 3'd3,
        S_CAS = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [4:0] r_tick;
    logic       r_active;
    logic       r_refresh;
    logic       r_mux;
    logic       r_ras_n;
    logic       r_cas_n;
    logic [7:0] r_refc;

    logic       w_resync;
    logic [4:0] w_tick_nxt;
    logic [3:0] w_local_nxt;
    logic       w_active_nxt;
    logic       w_refresh_nxt;
    logic       w_mux_nxt;
    logic       w_ras_n_nxt;
    logic       w_cas_n_nxt;
    logic       w_cas_block;
    logic       w_refc_dec;

    // A sync pulse only realigns when the counter is not already about to wrap.
    assign w_resync    = phi_sync && (r_tick != c_TICK_LAST);
    assign w_tick_nxt  = w_resync ? 5'd0 : (r_tick + 5'd1);
    assign w_local_nxt = w_tick_nxt[3:0];
    assign w_cas_block = c_RAS_ONLY && r_refresh;

    // A refresh half only counts once it reaches its closing precharge tick.
    assign w_refc_dec  = (r_state == S_CAS) && (w_local_nxt == 4'd15) && r_refresh;

    // Half-start sampling of the access/refresh flags; resync abandons the half.
    always_comb begin
        w_active_nxt  = r_active;
        w_refresh_nxt = r_refresh;
        if (w_resync) begin
            w_active_nxt  = 1'b0;
            w_refresh_nxt = 1'b0;
        end else if (r_tick == c_TICK_VIC) begin
            w_active_nxt  = vic_req | refresh;
            w_refresh_nxt = refresh;
        end else if (r_tick == c_TICK_CPU) begin
            w_active_nxt  = cpu_req;
            w_refresh_nxt = 1'b0;
        end
    end

    // Next state and next strobe levels, keyed on the tick being entered.
    always_comb begin
        w_state_nxt = r_state;
        if (w_resync) begin
            w_state_nxt = S_PRE;
        end else begin
            case (r_state)
                S_PRE: if (w_active_nxt && (w_local_nxt == 4'd5))  w_state_nxt = S_ROW;
                S_ROW: if (w_local_nxt == 4'd7)                    w_state_nxt = S_RAS;
                S_RAS: if (w_local_nxt == 4'd9)                    w_state_nxt = S_COL;
                S_COL: if (w_local_nxt == 4'd10)                   w_state_nxt = S_CAS;
                S_CAS: if (w_local_nxt == 4'd15)                   w_state_nxt = S_PRE;
                default:                                           w_state_nxt = S_PRE;
            endcase
        end

        w_mux_nxt   = 1'b1;
        w_ras_n_nxt = 1'b1;
        w_cas_n_nxt = 1'b1;
        case (w_state_nxt)
            S_ROW: begin
                w_ras_n_nxt = 1'b0;
            end
            S_RAS: begin
                w_ras_n_nxt = 1'b0;
                w_mux_nxt   = 1'b0;
            end
            S_COL, S_CAS: begin
                w_ras_n_nxt = 1'b0;
                w_mux_nxt   = 1'b0;
                w_cas_n_nxt = w_cas_block;
            end
            default: begin
                w_mux_nxt   = 1'b1;
            end
        endcase
    end

    // Tick counter, half flags and FSM state register.
    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            r_tick    <= c_TICK_LAST;
            r_active  <= 1'b0;
            r_refresh <= 1'b0;
            r_state   <= S_PRE;
        end else begin
            r_tick    <= w_tick_nxt;
            r_active  <= w_active_nxt;
            r_refresh <= w_refresh_nxt;
            r_state   <= w_state_nxt;
        end
    end

    // Registered DRAM strobes and address mux select.
    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            r_mux   <= 1'b1;
            r_ras_n <= 1'b1;
            r_cas_n <= 1'b1;
        end else begin
            r_mux   <= w_mux_nxt;
            r_ras_n <= w_ras_n_nxt;
            r_cas_n <= w_cas_n_nxt;
        end
    end

    // Refresh row counter: reload has priority over the end-of-refresh decrement.
    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            r_refc <= 8'hFF;
        end else if (refc_reload) begin
            r_refc <= 8'hFF;
        end else if (w_refc_dec) begin
            r_refc <= r_refc - 8'd1;
        end
    end

    // During a half-start tick the flag is not latched yet, so busy follows
    // the request input directly for that one tick.
    assign busy  = (r_tick == c_TICK_VIC) ? (vic_req | refresh) :
                   (r_tick == c_TICK_CPU) ? cpu_req : r_active;
    assign mux   = r_mux;
    assign ras_n = r_ras_n;
    assign cas_n = r_cas_n;
    assign refc  = r_refc;
    assign tick  = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_dram_strobe_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dram_strobe_seq
//  Description : Self-checking bench for dram_strobe_seq; directed phi cycles
//                plus randomized ones against a tick-level reference model.
//                Honours RAS_ONLY_REFRESH_EN when defined for the build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_strobe_seq;

`ifdef RAS_ONLY_REFRESH_EN
    localparam bit c_RAS_ONLY = 1'b1;
`else
    localparam bit c_RAS_ONLY = 1'b0;
`endif

    logic       clk_dot4x = 1'b0;
    logic       rst = 1'b1;
    logic       phi_sync = 1'b0;
    logic       vic_req = 1'b0;
    logic       refresh = 1'b0;
    logic       cpu_req = 1'b0;
    logic       refc_reload = 1'b0;
    logic       mux;
    logic       ras_n;
    logic       cas_n;
    logic [7:0] refc;
    logic [4:0] tick;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Reference model state: tick position, half flags, refresh counter.
    int m_tick = 31;
    bit m_act  = 1'b0;
    bit m_ref  = 1'b0;
    int m_refc = 255;

    dram_strobe_seq u_dut (
        .clk_dot4x   (clk_dot4x),
        .rst         (rst),
        .phi_sync    (phi_sync),
        .vic_req     (vic_req),
        .refresh     (refresh),
        .cpu_req     (cpu_req),
        .refc_reload (refc_reload),
        .mux         (mux),
        .ras_n       (ras_n),
        .cas_n       (cas_n),
        .refc        (refc),
        .tick        (tick),
        .busy        (busy)
    );

    always #5 clk_dot4x = ~clk_dot4x;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h at tick %0d", tag, obs, exp, m_tick);
        end
    endtask

    // Expected outputs follow from the local tick inside the current half.
    task automatic check_all();
        int  lt;
        bit  e_ras_low, e_mux_low, e_cas_low, e_busy;
        lt        = m_tick % 16;
        e_ras_low = m_act && (lt >= 5) && (lt <= 14);
        e_mux_low = m_act && (lt >= 7) && (lt <= 14);
        e_cas_low = m_act && (lt >= 9) && (lt <= 14) && !(c_RAS_ONLY && m_ref);
        if (m_tick == 0)       e_busy = vic_req | refresh;
        else if (m_tick == 16) e_busy = cpu_req;
        else                   e_busy = m_act;
        chk("tick",  8'(tick),  8'(m_tick));
        chk("ras_n", 8'(ras_n), 8'(!e_ras_low));
        chk("mux",   8'(mux),   8'(!e_mux_low));
        chk("cas_n", 8'(cas_n), 8'(!e_cas_low));
        chk("busy",  8'(busy),  8'(e_busy));
        chk("refc",  refc,      8'(m_refc));
    endtask

    // One clock: drive inputs, advance the model across the edge, then check.
    task automatic step(input bit r, input bit ps, input bit vr, input bit rf,
                        input bit cr, input bit rl);
        bit resync;
        rst = r; phi_sync = ps; vic_req = vr; refresh = rf; cpu_req = cr; refc_reload = rl;
        @(posedge clk_dot4x);
        if (r) begin
            m_tick = 31; m_act = 1'b0; m_ref = 1'b0; m_refc = 255;
        end else begin
            resync = ps && (m_tick != 31);
            if (!resync && (m_tick == 14) && m_act && m_ref)
                m_refc = (m_refc + 255) % 256;
            if (rl) m_refc = 255;
            if (resync) begin
                m_act = 1'b0; m_ref = 1'b0;
            end else if (m_tick == 0) begin
                m_act = vr | rf; m_ref = rf;
            end else if (m_tick == 16) begin
                m_act = cr; m_ref = 1'b0;
            end
            m_tick = resync ? 0 : (m_tick + 1) % 32;
        end
        #1;
        check_all();
    endtask

    // One phi cycle starting at tick 0; request inputs are random noise
    // outside their sample ticks. Optional reload / resync / reset events.
    task automatic phi_cycle(input bit vr, input bit rf, input bit cr,
                             input int rl_at, input int sync_at, input int rst_at);
        bit s_vr, s_rf, s_cr;
        for (int i = 0; i < 32; i++) begin
            s_vr = (i == 0)  ? vr : (($urandom & 1) != 0);
            s_rf = (i == 0)  ? rf : (($urandom & 1) != 0);
            s_cr = (i == 16) ? cr : (($urandom & 1) != 0);
            if (i == rst_at) begin
                step(1'b1, 1'b0, s_vr, s_rf, s_cr, 1'b0);
                step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                return;
            end
            if (i == sync_at) begin
                step(1'b0, 1'b1, s_vr, s_rf, s_cr, 1'b0);
                return;
            end
            step(1'b0, 1'b0, s_vr, s_rf, s_cr, i == rl_at);
        end
    endtask

    initial begin
        logic [7:0] saved_refc;

        // Reset state
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_tick", 8'(tick), 8'd31);
        chk("reset_refc", refc, 8'hFF);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("first_tick", 8'(tick), 8'd0);

        // VIC access, then CPU-only access
        phi_cycle(1'b1, 1'b0, 1'b0, -1, -1, -1);
        phi_cycle(1'b0, 1'b0, 1'b1, -1, -1, -1);

        // Three refresh halves
        repeat (3) phi_cycle(1'b0, 1'b1, 1'b0, -1, -1, -1);
        chk("refc_after3", refc, 8'hFC);

        // Walk the counter down to zero, then wrap
        repeat (252) phi_cycle(1'b0, 1'b1, 1'b0, -1, -1, -1);
        chk("refc_zero", refc, 8'h00);
        phi_cycle(1'b0, 1'b1, 1'b0, -1, -1, -1);
        chk("refc_wrap", refc, 8'hFF);

        // Reload coincident with the end-of-refresh decrement
        phi_cycle(1'b0, 1'b1, 1'b0, -1, -1, -1);
        chk("refc_dec", refc, 8'hFE);
        phi_cycle(1'b0, 1'b1, 1'b0, 14, -1, -1);
        chk("reload_wins", refc, 8'hFF);

        // Resync at tick 10 of an active refresh half
        saved_refc = refc;
        phi_cycle(1'b1, 1'b1, 1'b0, -1, 10, -1);
        chk("resync_tick", 8'(tick), 8'd0);
        chk("resync_ras",  8'(ras_n), 8'd1);
        chk("resync_refc", refc, saved_refc);

        // Reset at tick 11 of an active access
        phi_cycle(1'b0, 1'b1, 1'b0, -1, -1, 5'd0 + 11);
        chk("rst_refc", refc, 8'hFF);
        chk("rst_tick", 8'(tick), 8'd0);

        // Randomized phi cycles
        for (int k = 0; k < 60; k++) begin
            int sel;
            sel = $urandom_range(0, 9);
            phi_cycle((($urandom & 1) != 0), (($urandom & 3) == 0), (($urandom & 1) != 0),
                      (sel == 0) ? $urandom_range(0, 31) : -1,
                      (sel == 1) ? $urandom_range(1, 30) : -1,
                      (sel == 2) ? $urandom_range(1, 30) : -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
